route_sched: RTL and testbench

Route scheduler between the host UART receiver and `cmd_intf`. Buffers a list of destination station IDs sent by the host and issues them one at a time to `cmd_intf` as GO commands. Waits for each arrival (`in_transit` falling) plus a configurable dwell time before issuing the next. Owns the `cmd`/`cmd_rdy` pair that `cmd_intf` consumes and handles host STOP as a full route abort.

---
 rtl/line_follow_pkg.sv | 22 ++
 rtl/route_sched_if.sv | 23 ++
 rtl/route_sched_fifo.sv | 61 ++++++
 rtl/route_sched.sv | 184 ++++++++++++++++++
 tb/tb_route_sched.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_follow_pkg.sv
// Shared types for the line-follower route scheduler: host opcodes, scheduler
// state encoding and the station ID width.
package line_follow_pkg;

   localparam int ID_W = 6;

   typedef enum logic [1:0] {
      OP_STOP = 2'b00,
      OP_GO   = 2'b01,
      OP_ENQ  = 2'b10,
      OP_RUN  = 2'b11
   } cmd_op_t;

   typedef enum logic [2:0] {
      RS_IDLE     = 3'd0,
      RS_ISSUE    = 3'd1,
      RS_WAIT_ACK = 3'd2,
      RS_TRANSIT  = 3'd3,
      RS_DWELL    = 3'd4
   } route_state_t;

endpackage

// File: rtl/route_sched_if.sv
// Host-receiver and cmd_intf handshake signals seen by the route scheduler.
// slave = scheduler side, master = host/cmd_intf side.
interface route_sched_if;

   logic [7:0] rx_cmd;
   logic       rx_rdy;
   logic       clr_rx_rdy;
   logic [7:0] cmd;
   logic       cmd_rdy;
   logic       clr_cmd_rdy;
   logic       in_transit;

   modport slave (
      input  rx_cmd, rx_rdy, clr_cmd_rdy, in_transit,
      output clr_rx_rdy, cmd, cmd_rdy
   );

   modport master (
      output rx_cmd, rx_rdy, clr_cmd_rdy, in_transit,
      input  clr_rx_rdy, cmd, cmd_rdy
   );

endinterface

// File: rtl/route_sched_fifo.sv
// route_fifo: DEPTH x ID_W circular buffer holding pending station IDs.
// Push with pop is accepted even when full; flush overrides both.
module route_fifo
   import line_follow_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic [ID_W-1:0]               din,
   output logic [ID_W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0]    cnt,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ID_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_cnt == CNT_W'(DEPTH));
   assign empty     = (r_cnt == '0);
   assign cnt       = r_cnt;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !flush && !empty;
   assign w_do_push = push && !flush && (!full || pop);

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/route_sched.sv
// Route scheduler: queues host station IDs and dispatches them to cmd_intf as
// GO commands, waiting for arrival plus a dwell. Optional ROUTE_SCHED_LOOP_EN repeats the route.
module route_sched
   import line_follow_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int DWELL_CYCLES = 50000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   route_sched_if.slave               bus,
   output logic [$clog2(DEPTH+1)-1:0] q_cnt,
   output logic                       q_full,
   output logic                       q_ovfl,
   output logic                       route_busy
);

   localparam int DW_W = $clog2(DWELL_CYCLES+1);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES-1);

   localparam logic [2:0] ST_IDLE     = RS_IDLE;
   localparam logic [2:0] ST_ISSUE    = RS_ISSUE;
   localparam logic [2:0] ST_WAIT_ACK = RS_WAIT_ACK;
   localparam logic [2:0] ST_TRANSIT  = RS_TRANSIT;
   localparam logic [2:0] ST_DWELL    = RS_DWELL;

   logic [2:0]      r_state;
   logic [7:0]      r_cmd;
   logic            r_cmd_rdy;
   logic            r_fwd;
   logic            r_stop_pend;
   logic            r_seen_hi;
   logic            r_ovfl;
   logic [DW_W-1:0] r_dwell_cnt;

   cmd_op_t         w_op;
   logic            w_stop;
   logic            w_go;
   logic            w_enq;
   logic            w_run;
   logic            w_pop;
   logic            w_push;
   logic            w_enq_drop;
   logic [ID_W-1:0] w_din;
   logic [ID_W-1:0] w_head;
   logic            w_full;
   logic            w_empty;

   assign w_op   = cmd_op_t'(bus.rx_cmd[7:6]);
   assign w_stop = bus.rx_rdy && (w_op == OP_STOP);
   assign w_go   = bus.rx_rdy && (w_op == OP_GO);
   assign w_enq  = bus.rx_rdy && (w_op == OP_ENQ);
   assign w_run  = bus.rx_rdy && (w_op == OP_RUN);

   assign bus.clr_rx_rdy = bus.rx_rdy;
   assign bus.cmd        = r_cmd;
   assign bus.cmd_rdy    = r_cmd_rdy;
   assign q_full         = w_full;
   assign q_ovfl         = r_ovfl;
   assign route_busy     = (r_state != ST_IDLE);

   assign w_pop = (r_state == ST_ISSUE) && !w_stop && !w_empty;

`ifdef ROUTE_SCHED_LOOP_EN
   // The re-push of the popped head owns the write port; a host ENQ that
   // lands in the same cycle is dropped and flagged.
   assign w_push     = w_pop || w_enq;
   assign w_din      = w_pop ? w_head : bus.rx_cmd[ID_W-1:0];
   assign w_enq_drop = w_enq && (w_pop || w_full);
`else
   assign w_push     = w_enq;
   assign w_din      = bus.rx_cmd[ID_W-1:0];
   assign w_enq_drop = w_enq && w_full && !w_pop;
`endif

   route_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .flush (w_stop),
      .din   (w_din),
      .dout  (w_head),
      .cnt   (q_cnt),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovfl <= 1'b0;
      end else if (w_stop) begin
         r_ovfl <= 1'b0;
      end else if (w_enq_drop) begin
         r_ovfl <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cmd       <= 8'h00;
         r_cmd_rdy   <= 1'b0;
         r_fwd       <= 1'b0;
         r_stop_pend <= 1'b0;
         r_seen_hi   <= 1'b0;
         r_dwell_cnt <= '0;
      end else if (w_stop) begin
         r_seen_hi   <= 1'b0;
         r_dwell_cnt <= '0;
         // cmd may only change once the outstanding command has been acked
         if (!r_cmd_rdy || bus.clr_cmd_rdy) begin
            r_cmd       <= 8'h00;
            r_cmd_rdy   <= 1'b1;
            r_fwd       <= 1'b1;
            r_stop_pend <= 1'b0;
            r_state     <= ST_WAIT_ACK;
         end else begin
            r_stop_pend <= 1'b1;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_cmd     <= bus.rx_cmd;
                  r_cmd_rdy <= 1'b1;
                  r_fwd     <= 1'b1;
                  r_state   <= ST_WAIT_ACK;
               end else if (w_run && !w_empty) begin
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!w_empty) begin
                  r_cmd     <= {2'b01, w_head};
                  r_cmd_rdy <= 1'b1;
                  r_fwd     <= 1'b0;
                  r_state   <= ST_WAIT_ACK;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WAIT_ACK: begin
               if (bus.clr_cmd_rdy) begin
                  r_cmd_rdy <= 1'b0;
                  if (r_stop_pend) begin
                     r_cmd       <= 8'h00;
                     r_cmd_rdy   <= 1'b1;
                     r_stop_pend <= 1'b0;
                     r_fwd       <= 1'b1;
                  end else if (r_fwd) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_seen_hi <= 1'b0;
                     r_state   <= ST_TRANSIT;
                  end
               end
            end
            ST_TRANSIT: begin
               // Arrival is the falling edge of in_transit after it was seen high
               if (r_seen_hi && !bus.in_transit) begin
                  r_seen_hi   <= 1'b0;
                  r_dwell_cnt <= '0;
                  r_state     <= (q_cnt != '0) ? ST_DWELL : ST_IDLE;
               end else if (bus.in_transit) begin
                  r_seen_hi <= 1'b1;
               end
            end
            ST_DWELL: begin
               if (r_dwell_cnt == DWELL_LAST) begin
                  r_dwell_cnt <= '0;
                  r_state     <= ST_ISSUE;
               end else begin
                  r_dwell_cnt <= r_dwell_cnt + DW_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_route_sched.sv
// Directed bench for route_sched (DEPTH=4, short dwell); loop-mode scenario
// runs only when ROUTE_SCHED_LOOP_EN is defined.
module tb_route_sched;

   localparam int DEPTH = 4;
   localparam int DWELL = 5;

   logic       clk;
   logic       rst_n;
   logic [2:0] q_cnt;
   logic       q_full;
   logic       q_ovfl;
   logic       route_busy;
   int         checks;
   int         failures;

   route_sched_if bus ();

   route_sched #(
      .DEPTH        (DEPTH),
      .DWELL_CYCLES (DWELL)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .q_cnt      (q_cnt),
      .q_full     (q_full),
      .q_ovfl     (q_ovfl),
      .route_busy (route_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_cmd = b;
      bus.rx_rdy = 1'b1;
      #1;
      chk("clr_rx_rdy", bus.clr_rx_rdy, 1'b1);
      @(posedge clk);
      #1;
      bus.rx_rdy = 1'b0;
   endtask

   task automatic ack();
      bus.clr_cmd_rdy = 1'b1;
      tick(1);
      bus.clr_cmd_rdy = 1'b0;
   endtask

   task automatic arrive();
      bus.in_transit = 1'b1;
      tick(2);
      bus.in_transit = 1'b0;
   endtask

   task automatic wait_rdy(input string tag, input int max);
      int k;
      k = 0;
      while (!bus.cmd_rdy && k < max) begin
         tick(1);
         k++;
      end
      chk(tag, bus.cmd_rdy, 1'b1);
   endtask

   initial begin
      int n;
      int saw;
      logic [7:0] loop_exp [4];
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      bus.rx_cmd      = 8'h00;
      bus.rx_rdy      = 1'b0;
      bus.clr_cmd_rdy = 1'b0;
      bus.in_transit  = 1'b0;
      loop_exp        = '{8'h41, 8'h42, 8'h41, 8'h42};

      // reset values
      tick(2);
      chk("rst_cmd", bus.cmd, 8'h00);
      chk("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
      chk("rst_q_cnt", q_cnt, 3'd0);
      chk("rst_q_ovfl", q_ovfl, 1'b0);
      chk("rst_q_full", q_full, 1'b0);
      chk("rst_busy", route_busy, 1'b0);
      chk("idle_clr_rx", bus.clr_rx_rdy, 1'b0);
      rst_n = 1'b1;
      tick(1);

`ifndef ROUTE_SCHED_LOOP_EN
      // two-stop route
      send(8'h85);
      send(8'h8A);
      chk("route_q_cnt2", q_cnt, 3'd2);
      send(8'hC0);
      chk("run_issue_busy", route_busy, 1'b1);
      chk("run_issue_rdy", bus.cmd_rdy, 1'b0);
      tick(1);
      chk("go1_rdy", bus.cmd_rdy, 1'b1);
      chk("go1_cmd", bus.cmd, 8'h45);
      chk("go1_q_cnt", q_cnt, 3'd1);
      tick(2);
      chk("go1_hold", bus.cmd, 8'h45);
      ack();
      chk("go1_acked", bus.cmd_rdy, 1'b0);
      arrive();
      n = 0;
      while (!bus.cmd_rdy && n < 100) begin
         tick(1);
         n++;
      end
      chk("dwell_latency", n, DWELL + 2);
      chk("go2_cmd", bus.cmd, 8'h4A);
      chk("go2_q_cnt", q_cnt, 3'd0);
      ack();
      arrive();
      tick(1);
      chk("route_end_idle", route_busy, 1'b0);
      chk("route_end_cnt", q_cnt, 3'd0);

      // overflow then STOP
      send(8'h81);
      send(8'h82);
      send(8'h83);
      send(8'h84);
      chk("full_no_ovfl", q_ovfl, 1'b0);
      send(8'h85);
      chk("ovfl_q_cnt", q_cnt, 3'd4);
      chk("ovfl_q_full", q_full, 1'b1);
      chk("ovfl_flag", q_ovfl, 1'b1);
      send(8'h00);
      chk("stop_q_cnt", q_cnt, 3'd0);
      chk("stop_ovfl_clr", q_ovfl, 1'b0);
      chk("stop_cmd", bus.cmd, 8'h00);
      chk("stop_rdy", bus.cmd_rdy, 1'b1);
      ack();
      chk("stop_idle", route_busy, 1'b0);

      // STOP while GO pending ack
      send(8'h85);
      send(8'h86);
      send(8'hC0);
      tick(1);
      chk("pend_go_cmd", bus.cmd, 8'h45);
      send(8'h00);
      chk("pend_hold_cmd", bus.cmd, 8'h45);
      chk("pend_hold_rdy", bus.cmd_rdy, 1'b1);
      chk("pend_flush", q_cnt, 3'd0);
      tick(2);
      chk("pend_hold_cmd2", bus.cmd, 8'h45);
      ack();
      chk("pend_stop_cmd", bus.cmd, 8'h00);
      chk("pend_stop_rdy", bus.cmd_rdy, 1'b1);
      ack();
      chk("pend_idle", route_busy, 1'b0);
      chk("pend_rdy_low", bus.cmd_rdy, 1'b0);

      // GO forwarded in IDLE, dropped in TRANSIT
      send(8'h47);
      chk("fwd_go_cmd", bus.cmd, 8'h47);
      chk("fwd_go_rdy", bus.cmd_rdy, 1'b1);
      ack();
      chk("fwd_go_idle", route_busy, 1'b0);
      send(8'h89);
      send(8'hC0);
      tick(1);
      chk("t_go_cmd", bus.cmd, 8'h49);
      ack();
      send(8'h47);
      chk("t_drop_rdy", bus.cmd_rdy, 1'b0);
      chk("t_drop_cmd", bus.cmd, 8'h49);
      chk("t_drop_busy", route_busy, 1'b1);
      arrive();
      tick(1);
      chk("t_end_idle", route_busy, 1'b0);

      // ENQ while full coinciding with a pop
      send(8'h91);
      send(8'h92);
      send(8'h93);
      send(8'h94);
      send(8'hC0);
      send(8'h95);
      chk("fullpop_cnt", q_cnt, 3'd4);
      chk("fullpop_ovfl", q_ovfl, 1'b0);
      chk("fullpop_cmd", bus.cmd, 8'h51);
      send(8'h00);
      ack();
      chk("fullpop_stop_cmd", bus.cmd, 8'h00);
      ack();
      chk("fullpop_idle", route_busy, 1'b0);

      // STOP in the same cycle as the ISSUE pop
      send(8'h83);
      send(8'h84);
      send(8'hC0);
      send(8'h00);
      chk("stoppop_cnt", q_cnt, 3'd0);
      chk("stoppop_cmd", bus.cmd, 8'h00);
      chk("stoppop_rdy", bus.cmd_rdy, 1'b1);
      ack();
      chk("stoppop_idle", route_busy, 1'b0);
`else
      // looping route
      send(8'h81);
      send(8'h82);
      send(8'hC0);
      for (int i = 0; i < 4; i++) begin
         wait_rdy("loop_wait", 100);
         chk("loop_cmd", bus.cmd, loop_exp[i]);
         chk("loop_q_cnt", q_cnt, 3'd2);
         ack();
         arrive();
      end
      tick(1);
      chk("loop_dwell_busy", route_busy, 1'b1);
      send(8'h00);
      chk("loop_stop_cmd", bus.cmd, 8'h00);
      ack();
      chk("loop_stop_idle", route_busy, 1'b0);
      chk("loop_stop_cnt", q_cnt, 3'd0);
`endif

      // reset while dwelling
      send(8'h81);
      send(8'h82);
      send(8'hC0);
      tick(1);
      chk("rd_go_cmd", bus.cmd, 8'h41);
      ack();
      arrive();
      tick(1);
      chk("rd_dwell_busy", route_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rd_cmd", bus.cmd, 8'h00);
      chk("rd_rdy", bus.cmd_rdy, 1'b0);
      chk("rd_q_cnt", q_cnt, 3'd0);
      chk("rd_busy", route_busy, 1'b0);
      chk("rd_ovfl", q_ovfl, 1'b0);
      tick(1);
      rst_n = 1'b1;
      saw = 0;
      for (int i = 0; i < DWELL + 6; i++) begin
         tick(1);
         if (bus.cmd_rdy) saw = 1;
      end
      chk("rd_no_cmd", saw, 0);
      chk("rd_idle", route_busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
